// File: rtl/alu12_dispatch.sv
// alu12_dispatch
//   Operand sequencer that runs a 12-bit operation through an external
//   W-bit ripple ALU in two passes: low half (LO), then high half (HI).
//   The low-half carry-out is registered and fed back as the high-half
//   carry-in for ADD/SUB, so the pair of passes behaves like one 2W-bit
//   add or subtract.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_op/req_a/req_b captured at accept
//   resp_valid/ready  response handshake; resp_result/carry/overflow held
//                     stable while resp_valid is high
//   alu_a/b/carry_in/op   drive to the ALU slice (combinational from state)
//   alu_result/carry_out  ALU outputs, consumed in the same cycle
module alu12_dispatch #(
  parameter int         W      = 6,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SUB = 4'b0110
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*W-1:0] resp_result,
  output logic           resp_carry,
  output logic           resp_overflow,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_carry_in,
  output logic [3:0]     alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carry_out
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [2*W-1:0]   a_q, a_d;
  logic [2*W-1:0]   b_q, b_d;
  logic [W-1:0]     res_lo_q, res_lo_d;
  logic             c_mid_q, c_mid_d;
  logic [2*W-1:0]   resp_result_q, resp_result_d;
  logic             resp_carry_q, resp_carry_d;
  logic             resp_overflow_q, resp_overflow_d;

  logic             is_add;
  logic             is_sub;
  logic             is_arith;

  // Two's-complement overflow from sign bits only. For subtract the ALU
  // adds ~b, so overflow needs operands of differing sign instead of equal.
  function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    return (((a_msb ^ b_msb) == sub) && (r_msb != a_msb));
  endfunction

  assign is_add   = (op_q == OP_ADD);
  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = is_add || is_sub;

  // Next-state and capture logic
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    a_d             = a_q;
    b_d             = b_q;
    res_lo_d        = res_lo_q;
    c_mid_d         = c_mid_q;
    resp_result_d   = resp_result_q;
    resp_carry_d    = resp_carry_q;
    resp_overflow_d = resp_overflow_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = LO;
        end
      end
      LO: begin
        res_lo_d = alu_result;
        c_mid_d  = alu_carry_out;
        state_d  = HI;
      end
      HI: begin
        resp_result_d   = {alu_result, res_lo_q};
        resp_carry_d    = is_arith ? alu_carry_out : 1'b0;
        resp_overflow_d = is_arith ? signed_ovf(is_sub, a_q[2*W-1], b_q[2*W-1],
                                                alu_result[W-1]) : 1'b0;
        state_d         = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: zero outside the two passes so the slice sees a quiet bus
  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;
    alu_carry_in = 1'b0;
    case (state_q)
      LO: begin
        alu_a        = a_q[W-1:0];
        alu_b        = b_q[W-1:0];
        alu_op       = op_q;
        alu_carry_in = is_sub;
      end
      HI: begin
        alu_a        = a_q[2*W-1:W];
        alu_b        = b_q[2*W-1:W];
        alu_op       = op_q;
        alu_carry_in = is_arith ? c_mid_q : 1'b0;
      end
      default: ;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      resp_result_q   <= '0;
      resp_carry_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      resp_result_q   <= resp_result_d;
      resp_carry_q    <= resp_carry_d;
      resp_overflow_q <= resp_overflow_d;
    end
  end

  // Operand and intermediate registers: only observed in LO/HI, which are
  // always entered through a fresh capture, so they need no reset.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    a_q      <= a_d;
    b_q      <= b_d;
    res_lo_q <= res_lo_d;
    c_mid_q  <= c_mid_d;
  end

  assign req_ready     = rst_n && (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_result   = resp_result_q;
  assign resp_carry    = resp_carry_q;
  assign resp_overflow = resp_overflow_q;

endmodule

// File: tb/tb_alu12_dispatch.sv
// tb_alu12_dispatch
//   Drives alu12_dispatch with directed and random 12-bit operations. A
//   behavioural 6-bit ALU slice sits on the alu_* bus, and expected results
//   come from plain 12-bit arithmetic on the original operands.
module tb_alu12_dispatch;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [11:0] req_a;
  logic [11:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_result;
  logic        resp_carry;
  logic        resp_overflow;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic        alu_carry_in;
  logic [3:0]  alu_op;
  logic [5:0]  alu_result;
  logic        alu_carry_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu12_dispatch #(.W(6), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_carry   (resp_carry),
    .resp_overflow(resp_overflow),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_carry_in (alu_carry_in),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry_out(alu_carry_out)
  );

  // 6-bit ripple ALU slice: ALUOp[3]=Ainvert, [2]=Bnegate, [1:0]=select.
  // Carry-out always comes from the adder, as in the real slice.
  logic [5:0] alu_aa, alu_bb;
  logic [6:0] alu_sum;
  always_comb begin
    alu_aa        = alu_op[3] ? ~alu_a : alu_a;
    alu_bb        = alu_op[2] ? ~alu_b : alu_b;
    alu_sum       = {1'b0, alu_aa} + {1'b0, alu_bb} + {6'b0, alu_carry_in};
    alu_carry_out = alu_sum[6];
    alu_result    = '0;
    case (alu_op[1:0])
      2'b00:   alu_result = alu_aa & alu_bb;
      2'b01:   alu_result = alu_aa | alu_bb;
      2'b10:   alu_result = alu_sum[5:0];
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: 12-bit arithmetic on the original operands.
  function automatic void ref12(input logic [3:0] op, input logic [11:0] a,
                                input logic [11:0] b, output logic [11:0] r,
                                output logic c, output logic v);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = int'(a) + int'(b);
        r = 12'(s);
        c = (s > 4095);
        v = ((sa + sb) > 2047) || ((sa + sb) < -2048);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        v = ((sa - sb) > 2047) || ((sa - sb) < -2048);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      default: r = '0;
    endcase
  endfunction

  // Called at #1 after an edge with resp_ready=0 and the DUT idle.
  task automatic run_txn(input logic [3:0] op, input logic [11:0] a,
                         input logic [11:0] b, input int stall);
    logic [11:0] er;
    logic        ec, ev, c_lo;
    int          waited;
    ref12(op, a, b, er, ec, ev);
    if (op == OP_ADD)      c_lo = (int'(a[5:0]) + int'(b[5:0])) > 63;
    else if (op == OP_SUB) c_lo = (a[5:0] >= b[5:0]);
    else                   c_lo = 1'b0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble inputs to show the operation uses the captured copy.
    req_valid = 1'b0;
    req_a = 12'($urandom); req_b = 12'($urandom); req_op = 4'($urandom);
    chk("lo_alu_a", 32'(alu_a), 32'(a[5:0]));
    chk("lo_alu_b", 32'(alu_b), 32'(b[5:0]));
    chk("lo_alu_op", 32'(alu_op), 32'(op));
    chk("lo_cin", 32'(alu_carry_in), 32'(op == OP_SUB));
    chk("lo_req_ready", 32'(req_ready), 32'd0);
    chk("lo_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("hi_alu_a", 32'(alu_a), 32'(a[11:6]));
    chk("hi_alu_b", 32'(alu_b), 32'(b[11:6]));
    chk("hi_alu_op", 32'(alu_op), 32'(op));
    chk("hi_cin", 32'(alu_carry_in), 32'(c_lo));
    chk("hi_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("done_valid", 32'(resp_valid), 32'd1);
    chk("done_result", 32'(resp_result), 32'(er));
    chk("done_carry", 32'(resp_carry), 32'(ec));
    chk("done_ovf", 32'(resp_overflow), 32'(ev));
    chk("done_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_a = 12'($urandom); req_b = 12'($urandom); req_op = OP_ADD;
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_result", 32'(resp_result), 32'(er));
      chk("stall_carry", 32'(resp_carry), 32'(ec));
      chk("stall_ovf", 32'(resp_overflow), 32'(ev));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_alu_a", 32'(alu_a), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("taken_valid", 32'(resp_valid), 32'd0);
    chk("taken_req_ready", 32'(req_ready), 32'd1);
    chk("taken_hold_result", 32'(resp_result), 32'(er));
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [11:0] exp_q [$];
    logic [11:0] er, ra, rb;
    logic        ec, ev;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT};

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", 32'(resp_result), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_carry", 32'(resp_carry), 32'd0);
    chk("post_rst_ovf", 32'(resp_overflow), 32'd0);
    @(posedge clk); #1;

    // Directed operations, including carry/overflow boundaries
    run_txn(OP_ADD, 12'h03F, 12'h001, 0);
    run_txn(OP_ADD, 12'hFFF, 12'h001, 0);
    run_txn(OP_ADD, 12'h7FF, 12'h001, 0);
    run_txn(OP_SUB, 12'h800, 12'h001, 0);
    run_txn(OP_SUB, 12'h005, 12'h007, 0);
    run_txn(OP_AND, 12'hA5A, 12'h0FF, 5);
    run_txn(OP_SLT, 12'hFFF, 12'hFFF, 1);

    // Back-to-back: req_valid and resp_ready held high
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      chk("b2b_req_ready", 32'(req_ready), 32'(s % 4 == 0));
      chk("b2b_resp_valid", 32'(resp_valid), 32'(s % 4 == 3));
      if (s % 4 == 0) begin
        ra = 12'($urandom); rb = 12'($urandom);
        req_op = OP_ADD; req_a = ra; req_b = rb;
        ref12(OP_ADD, ra, rb, er, ec, ev);
        exp_q.push_back(er);
      end else begin
        req_a = 12'($urandom); req_b = 12'($urandom);
      end
      if (s % 4 == 3 && exp_q.size() > 0) chk("b2b_result", 32'(resp_result), 32'(exp_q.pop_front()));
      if (s == 15) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    chk("b2b_end_ready", 32'(req_ready), 32'd1);

    // Reset while in HI drops the transaction
    req_op = OP_ADD; req_a = 12'h321; req_b = 12'h111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_in_hi", 32'(alu_a), 32'(6'h0C));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_cin", 32'(alu_carry_in), 32'd0);
    chk("mid_rst_resp_result", 32'(resp_result), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("after_rst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("dropped_resp_valid", 32'(resp_valid), 32'd0);
    end
    run_txn(OP_ADD, 12'h123, 12'h456, 0);

    // Random operations with random backpressure
    for (int i = 0; i < 30; i++) begin
      run_txn(ops[$urandom_range(0, 5)], 12'($urandom), 12'($urandom),
              int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
